// File: rtl/xor_chk_pkg.sv
// Shared types and constants for the XOR frame checksum endpoint.
// Holds the FSM state encoding, default sizes and the counter width helper.
// Imported by both the top module and the saturating word counter.
package xor_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } chk_state_t;

    localparam int NB_DEFAULT        = 16;
    localparam int MAX_WORDS_DEFAULT = 8;

    // Width needed to hold a count in the range 0..max inclusive.
    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/sat_word_counter.sv
// Purpose: per-frame word counter that saturates at MAX_WORDS_G and flags it.
// Latency: count updates on the edge after i_clr/i_inc; o_at_max is combinational from the count.
// Backpressure: none; the caller decides when a word is consumed.
module sat_word_counter
    import xor_chk_pkg::*;
#(
    parameter int MAX_WORDS_G = MAX_WORDS_DEFAULT
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_clr,
    input  logic                                i_inc,
    output logic [cnt_width(MAX_WORDS_G)-1:0]   o_cnt,
    output logic                                o_at_max
);

    localparam int            CW    = cnt_width(MAX_WORDS_G);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_WORDS_G);

    logic [CW-1:0] r_cnt;
    logic          w_at_max;

    assign w_at_max = (r_cnt == MAX_C);

    // Clear restarts the count (at 1 when the clearing word itself is counted); otherwise count up to the ceiling and stick there.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? CW'(1) : '0;
        end else if (i_inc && !w_at_max) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_at_max = w_at_max;

endmodule

// File: rtl/xor_frame_checksum.sv
// Purpose: XOR-accumulates a valid/ready framed word stream into a checksum with word count and overflow flag.
// Latency: chk_valid_o rises one cycle after the edge accepting the last word; one word per cycle within a frame.
// Backpressure: ready_o is low while a result waits in OUT (one bubble between frames); result held until chk_ready_i.
module xor_frame_checksum
    import xor_chk_pkg::*;
#(
    parameter int NB_G        = NB_DEFAULT,
    parameter int MAX_WORDS_G = MAX_WORDS_DEFAULT
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                valid_i,
    input  logic [NB_G-1:0]                     data_i,
    input  logic                                last_i,
    output logic                                ready_o,
    output logic                                chk_valid_o,
    input  logic                                chk_ready_i,
    output logic [NB_G-1:0]                     chk_o,
    output logic [cnt_width(MAX_WORDS_G)-1:0]   cnt_o,
    output logic                                err_o
);

    chk_state_t             r_state;
    logic [NB_G-1:0]        r_acc;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_clr;
    logic                   w_inc;
    logic                   w_at_max;
    logic [cnt_width(MAX_WORDS_G)-1:0] w_cnt;

    // Ready is forced low during reset so nothing is taken while the block is held.
    assign ready_o  = rst_ni && (r_state != OUT);
    assign w_accept = valid_i && ready_o;

    // The first word of a frame restarts the count at 1; later words count only while below the ceiling.
    assign w_clr = w_accept && (r_state == IDLE);
    assign w_inc = w_accept && ((r_state == IDLE) || ((r_state == ACC) && !w_at_max));

    sat_word_counter #(
        .MAX_WORDS_G (MAX_WORDS_G)
    ) u_cnt (
        .i_clk    (clk_i),
        .i_rst_n  (rst_ni),
        .i_clr    (w_clr),
        .i_inc    (w_inc),
        .o_cnt    (w_cnt),
        .o_at_max (w_at_max)
    );

    // Frame FSM and checksum accumulator; acc/err are frozen outside accepting states so results stay stable in OUT and IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc   <= data_i;
                        r_err   <= 1'b0;
                        r_state <= last_i ? OUT : ACC;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        if (!w_at_max) begin
                            r_acc   <= r_acc ^ data_i;
                            r_state <= last_i ? OUT : ACC;
                        end else begin
                            // Word beyond the ceiling: dropped, frame marked as overflowed.
                            r_err   <= 1'b1;
                            r_state <= last_i ? OUT : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_accept && last_i) begin
                        r_state <= OUT;
                    end
                end
                OUT: begin
                    if (chk_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign chk_valid_o = (r_state == OUT);
    assign chk_o       = r_acc;
    assign cnt_o       = w_cnt;
    assign err_o       = r_err;

endmodule

// File: tb/tb_xor_frame_checksum.sv
module tb_xor_frame_checksum;

    localparam int NB  = 16;
    localparam int MAX = 8;
    localparam int CW  = xor_chk_pkg::cnt_width(MAX);

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           valid_i = 1'b0;
    logic [NB-1:0]  data_i = '0;
    logic           last_i = 1'b0;
    logic           ready_o;
    logic           chk_valid_o;
    logic           chk_ready_i = 1'b0;
    logic [NB-1:0]  chk_o;
    logic [CW-1:0]  cnt_o;
    logic           err_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: words of the frame in progress, and the pending result.
    logic [NB-1:0]  fq[$];
    bit             pending = 1'b0;
    logic [NB-1:0]  m_chk = '0;
    int             m_cnt = 0;
    bit             m_err = 1'b0;

    xor_frame_checksum #(.NB_G(NB), .MAX_WORDS_G(MAX)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .data_i      (data_i),
        .last_i      (last_i),
        .ready_o     (ready_o),
        .chk_valid_o (chk_valid_o),
        .chk_ready_i (chk_ready_i),
        .chk_o       (chk_o),
        .cnt_o       (cnt_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model outputs compared on the falling edge each cycle.
    task automatic compare_model();
        check("ready", {31'b0, ready_o}, {31'b0, !pending});
        check("chk_valid", {31'b0, chk_valid_o}, {31'b0, pending});
        if (pending) begin
            check("chk", {16'b0, chk_o}, {16'b0, m_chk});
            check("cnt", {{(32-CW){1'b0}}, cnt_o}, 32'(m_cnt));
            check("err", {31'b0, err_o}, {31'b0, m_err});
        end
    endtask

    // Model step from the inputs applied this cycle.
    task automatic model_update(input logic v, input logic [NB-1:0] d, input logic l, input logic cr);
        int n;
        if (pending) begin
            if (cr) pending = 1'b0;
        end else if (v) begin
            fq.push_back(d);
            if (l) begin
                n     = fq.size();
                m_cnt = (n < MAX) ? n : MAX;
                m_err = (n > MAX);
                m_chk = '0;
                for (int i = 0; i < m_cnt; i++) m_chk ^= fq[i];
                fq.delete();
                pending = 1'b1;
            end
        end
    endtask

    task automatic step(input logic v, input logic [NB-1:0] d, input logic l, input logic cr);
        @(negedge clk_i);
        compare_model();
        valid_i     = v;
        data_i      = d;
        last_i      = l;
        chk_ready_i = cr;
        model_update(v, d, l, cr);
        @(posedge clk_i);
    endtask

    // Literal expectations sampled just after the active edge.
    task automatic pin(input string name, input logic [NB-1:0] c, input int n, input logic e);
        #1;
        check({name, "_vld"}, {31'b0, chk_valid_o}, 32'd1);
        check({name, "_chk"}, {16'b0, chk_o}, {16'b0, c});
        check({name, "_cnt"}, {{(32-CW){1'b0}}, cnt_o}, 32'(n));
        check({name, "_err"}, {31'b0, err_o}, {31'b0, e});
    endtask

    logic [NB-1:0] held;

    initial begin
        // Reset state
        #1;
        check("rst_ready", {31'b0, ready_o}, 32'd0);
        check("rst_vld", {31'b0, chk_valid_o}, 32'd0);
        check("rst_chk", {16'b0, chk_o}, 32'd0);
        check("rst_cnt", {{(32-CW){1'b0}}, cnt_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        #11 rst_ni = 1'b1;
        #1 check("rel_ready", {31'b0, ready_o}, 32'd1);

        // Three-word frame
        step(1, 16'hFFFF, 0, 1);
        step(1, 16'h00FF, 0, 1);
        step(1, 16'h0F0F, 1, 1);
        pin("three", 16'hF00F, 3, 0);
        step(0, 16'h0000, 0, 1);
        #1 check("three_drop", {31'b0, chk_valid_o}, 32'd0);

        // Single-word frame
        step(1, 16'hA5A5, 1, 0);
        pin("single", 16'hA5A5, 1, 0);

        // Back-pressure: result held, 16'h1234 not taken while in OUT
        held = chk_o;
        for (int i = 0; i < 5; i++) begin
            step(1, 16'h1234, 1, 0);
            #1;
            check("bp_ready", {31'b0, ready_o}, 32'd0);
            check("bp_hold", {16'b0, chk_o}, {16'b0, held});
        end
        step(1, 16'h1234, 1, 1);
        #1 check("bp_bubble_done", {31'b0, ready_o}, 32'd1);
        step(1, 16'h1234, 1, 0);
        pin("bp_next", 16'h1234, 1, 0);
        step(0, 16'h0000, 0, 1);

        // Overflow: words 1..10, only 1..8 count
        for (int i = 1; i <= 10; i++) step(1, NB'(i), (i == 10), 0);
        pin("ovf", 16'h0008, 8, 1);
        step(0, 16'h0000, 0, 1);

        // Reset mid-frame, between edges
        step(1, 16'hAAAA, 0, 0);
        step(1, 16'h5555, 0, 0);
        valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("mid_rst_vld", {31'b0, chk_valid_o}, 32'd0);
        check("mid_rst_chk", {16'b0, chk_o}, 32'd0);
        check("mid_rst_cnt", {{(32-CW){1'b0}}, cnt_o}, 32'd0);
        check("mid_rst_ready", {31'b0, ready_o}, 32'd0);
        #1 rst_ni = 1'b1;
        fq.delete();
        pending = 1'b0;
        step(1, 16'h0F00, 1, 0);
        pin("post_rst", 16'h0F00, 1, 0);
        step(0, 16'h0000, 0, 1);

        // Back-to-back frames with a single bubble
        step(1, 16'h1111, 0, 1);
        step(1, 16'h2222, 1, 1);
        pin("b2b_a", 16'h3333, 2, 0);
        check("b2b_bubble", {31'b0, ready_o}, 32'd0);
        step(1, 16'h4444, 1, 1);
        #1 check("b2b_ready_back", {31'b0, ready_o}, 32'd1);
        step(1, 16'h4444, 1, 1);
        pin("b2b_b", 16'h4444, 1, 0);
        step(0, 16'h0000, 0, 1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), NB'($urandom), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 1) == 1));
        end
        @(negedge clk_i);
        compare_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/xor_frame_checksum.md
Name: xor_frame_checksum

Overview:
- Downstream consumer of the 16-bit XOR stage (`xor_nbits_nb_g16`).
- Its `data_i` is driven by that stage's `s_o`. It XOR-accumulates a frame of words, qualified by a valid/ready handshake, into a running checksum.
- At end of frame it presents the checksum, the word count and an overflow flag, and holds them until the consumer accepts.
- It turns the combinational XOR datapath into a framed, back-pressurable stream endpoint.

Parameters:
- NB_G, 16, data and checksum width in bits; must match the upstream XOR stage.
- MAX_WORDS_G, 8, maximum number of words accumulated per frame; must be >= 1.

Ports:
- clk_i  input  1  single system clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  `data_i`/`last_i` are valid this cycle.
- data_i  input  NB_G  word to accumulate, from the XOR stage's `s_o`.
- last_i  input  1  the current word is the final word of its frame.
- ready_o  output  1  block can accept a word this cycle.
- chk_valid_o  output  1  `chk_o`/`cnt_o`/`err_o` hold a completed frame result.
- chk_ready_i  input  1  consumer accepts the result.
- chk_o  output  NB_G  XOR of all accumulated words in the frame.
- cnt_o  output  $clog2(MAX_WORDS_G+1)  number of words accumulated (saturates at MAX_WORDS_G).
- err_o  output  1  frame exceeded MAX_WORDS_G; extra words were discarded.

Behaviour:
- Decided: one clock (`clk_i`); reset `rst_ni` is asynchronous and active-low.
- Reset (asynchronous, any time, including mid-frame or mid-result):
  - State goes to IDLE.
  - `chk_o`, `cnt_o`, `err_o`, `chk_valid_o` go to 0.
  - `ready_o` is 0 while `rst_ni` is low and 1 in the first cycle after release.
  - No partial frame survives reset.
- Accept: a word is consumed on a rising edge when `valid_i` && `ready_o`. Nothing else changes state except `chk_ready_i` in state OUT.
- IDLE (`ready_o`=1, `chk_valid_o`=0). On accept:
  - acc <= `data_i`; cnt <= 1; err <= 0.
  - If `last_i`=1, go to OUT; otherwise go to ACC.
- ACC (`ready_o`=1). On accept:
  - If cnt < MAX_WORDS_G: acc <= acc ^ `data_i`; cnt <= cnt+1. Then if `last_i`=1 go to OUT, otherwise stay in ACC.
  - If cnt == MAX_WORDS_G: word discarded; err <= 1. Then if `last_i`=1 go to OUT, otherwise go to DRAIN.
- DRAIN (`ready_o`=1):
  - Every accepted word is discarded; acc and cnt are frozen.
  - Accepting a word with `last_i`=1 moves the block to OUT.
- OUT (`ready_o`=0, `chk_valid_o`=1):
  - `chk_o`=acc, `cnt_o`=cnt, `err_o`=err; all three are stable while `chk_valid_o`=1.
  - When `chk_ready_i`=1, go to IDLE. `chk_valid_o` drops in the next cycle.
- Outputs `chk_o`/`cnt_o`/`err_o` keep their last values in IDLE. They are meaningful only when `chk_valid_o`=1.
- Latency: `chk_valid_o` rises one cycle after the edge that accepts the last word.
- Throughput: one word per cycle within a frame. There is exactly one bubble cycle between frames, because `ready_o`=0 in OUT even when `chk_ready_i`=1.
- `valid_i` with `ready_o`=0 is ignored, not queued. The upstream holds its word, per the standard valid/ready rule.
- `chk_ready_i` outside OUT has no effect.
- MAX_WORDS_G=1: every multi-word frame sets `err_o`.
- cnt never wraps; it saturates at MAX_WORDS_G.

Decomposition:
- Shared package `xor_chk_pkg`:
  - state enum `chk_state_t` {IDLE, ACC, DRAIN, OUT};
  - default constants NB_DEFAULT=16 and MAX_WORDS_DEFAULT=8;
  - function `cnt_width(max)` returning $clog2(max+1).
- One natural sub-module: `sat_word_counter` (clear, increment, saturate at MAX_WORDS_G, at_max flag).
- FSM and accumulator stay in the top module.

Test Plan:
- Three-word frame 16'hFFFF, 16'h00FF, 16'h0F0F (last on the third), `chk_ready_i`=1 -> next cycle: `chk_valid_o`=1, `chk_o`=16'hF00F, `cnt_o`=3, `err_o`=0; `chk_valid_o` drops one cycle later.
- Single-word frame 16'hA5A5 with `last_i`=1 from IDLE -> following cycle: `chk_o`=16'hA5A5, `cnt_o`=1, `err_o`=0.
- Back-pressure: hold `chk_ready_i`=0 for 5 cycles during OUT while `valid_i`=1 with 16'h1234 -> `ready_o`=0 and outputs stable for all 5 cycles; 16'h1234 is accepted only as the first word of the next frame, after the bubble.
- Overflow with MAX_WORDS_G=8: 10 words 16'h0001..16'h000A, last on the 10th -> `err_o`=1, `cnt_o`=8, `chk_o`=16'h0008 (XOR of 1..8); words 9 and 10 have no effect.
- Reset mid-frame: accept 16'hAAAA, 16'h5555, then pulse `rst_ni` low between edges -> `chk_valid_o`, `chk_o`, `cnt_o` go to 0 immediately, asynchronously. Then frame 16'h0F00 (last) -> `chk_o`=16'h0F00, `cnt_o`=1.
- Back-to-back frames {16'h1111, 16'h2222 last} then {16'h4444 last} with `chk_ready_i`=1 -> results 16'h3333/cnt 2, then 16'h4444/cnt 1, with exactly one `ready_o`=0 cycle between the frames.
